// File: rtl/multi_cycle_control.sv
// multi_cycle_control: sequencing FSM for the multi-cycle RV32I core.
// Steps one instruction through fetch/decode/execute/memory/writeback and
// drives every datapath select and enable. Memory states wait on mem_ready.
//
// Ports:
//   clk, reset_n        core clock, synchronous active-low reset
//   opcode[6:0]         instr[6:0] from the instruction register
//   zero                ALU zero flag (branch compare)
//   mem_ready           memory completes the current access this cycle
//   pc_en, ir_write     PC load, instruction/old-PC register load
//   adr_src             memory address select (0 = PC, 1 = ALUOut)
//   mem_read, mem_write memory requests
//   reg_write           register file write
//   alu_src_a/b, alu_op ALU operand selects and operation class
//   result_src          writeback source select
//   instr_done          one-cycle retire pulse
//   illegal             sticky unsupported-opcode trap
module multi_cycle_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       illegal
);

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_LUI       = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BEQ       = 4'd10,
        S_JAL       = 4'd11,
        S_JALR_ADR  = 4'd12,
        S_JALR      = 4'd13,
        S_ILLEGAL   = 4'd14
    } state_t;

    state_t state;
    state_t state_next;
    logic   illegal_q;

    // State register and sticky trap flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_q <= illegal_q | (state_next == S_ILLEGAL);
        end
    end

    // Next-state and output decode; reset forces every output low
    always_comb begin
        state_next = S_FETCH;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        instr_done = 1'b0;
        illegal    = illegal_q;

        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALUOut <= old_pc + imm (branch/jal target, auipc result)
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_R:     state_next = S_EXEC_R;
                    OP_I:     state_next = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE: state_next = S_MEM_ADR;
                    OP_BEQ:   state_next = S_BEQ;
                    OP_JAL:   state_next = S_JAL;
                    OP_JALR:  state_next = S_JALR_ADR;
                    OP_LUI:   state_next = S_LUI;
                    OP_AUIPC: state_next = S_ALU_WB;
                    default:  state_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read   = 1'b1;
                adr_src    = 1'b1;
                state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
                state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b11;
                state_next = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                // Compare rs1 - rs2; take the target held in ALUOut on zero
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL, S_JALR: begin
                // PC <= ALUOut target while ALU forms the link old_pc + 4
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_en      = 1'b1;
                state_next = S_ALU_WB;
            end
            S_JALR_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = S_JALR;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                state_next = S_ILLEGAL;
            end
            default: state_next = S_FETCH;
        endcase

        if (!reset_n) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            result_src = 2'b00;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle vector table with
// hand-computed output words, plus latency sequences per instruction class.
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_done, illegal;

    int total = 0;
    int bad   = 0;

    multi_cycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .instr_done(instr_done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BQ = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                           BADOP = 7'b1111111;

    // Output word: {pc_en, ir_write, adr_src, mem_read, mem_write, reg_write,
    //               a[1:0], b[1:0], alu_op[1:0], result_src[1:0], done, illegal}
    function automatic logic [16:0] o(input logic pe, input logic ir, input logic ad,
                                      input logic rd, input logic wr, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op, input logic [1:0] rs,
                                      input logic dn, input logic il);
        return {pe, ir, ad, rd, wr, rw, a, b, op, rs, dn, il};
    endfunction

    logic [16:0] Z, F_RDY, F_WAIT, DEC, EXR, EXI, LUI_O, AWB, MADR, MRD, MWB,
                 MWR_W, MWR_R, BEQ_T, BEQ_N, JMP, JADR, ILL;

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [16:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rn, input logic [6:0] op, input logic z,
                       input logic rdy, input logic [16:0] exp, input string tag);
        vec_t v;
        v.rst_n = rn; v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.tag = tag;
        vecs.push_back(v);
    endtask

    function automatic logic [16:0] actual();
        return {pc_en, ir_write, adr_src, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, instr_done, illegal};
    endfunction

    // Clock-by-clock check of a single instruction's retire latency
    task automatic latency(input logic [6:0] op, input logic z, input int stalls,
                           input int want, input string tag);
        int cyc;
        bit done_seen;
        cyc = 0;
        done_seen = 0;
        while (!done_seen && cyc < 30) begin
            @(negedge clk);
            reset_n   = 1'b1;
            opcode    = op;
            zero      = z;
            mem_ready = (cyc < stalls) ? 1'b0 : 1'b1;
            #1;
            cyc++;
            if (mem_read && mem_write) begin
                total++; bad++;
                $display("FAIL %s both_req: got rd=1 wr=1 want not both", tag);
            end
            if (instr_done) done_seen = 1;
        end
        total++;
        if (!done_seen || cyc != want) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles (done=%0b) want %0d",
                     tag, cyc, done_seen, want);
        end
    endtask

    initial begin
        reset_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;

        Z      = '0;
        F_RDY  = o(1,1,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
        F_WAIT = o(0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0);
        DEC    = o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
        EXR    = o(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0);
        EXI    = o(0,0,0,0,0,0, 2'b10,2'b01,2'b11,2'b00, 0,0);
        LUI_O  = o(0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 0,0);
        AWB    = o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0);
        MADR   = o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
        MRD    = o(0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
        MWB    = o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 1,0);
        MWR_W  = o(0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0);
        MWR_R  = o(0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 1,0);
        BEQ_T  = o(1,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0);
        BEQ_N  = o(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0);
        JMP    = o(1,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0);
        JADR   = o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
        ILL    = o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1);

        // Reset for 3 cycles, then R-type
        for (int i = 0; i < 3; i++) add(0, R, 0, 1, Z, "reset");
        add(1, R, 0, 1, F_RDY, "r_fetch");
        add(1, R, 0, 1, DEC,   "r_decode");
        add(1, R, 0, 1, EXR,   "r_exec");
        add(1, R, 0, 1, AWB,   "r_wb");
        // Load with two MEM_READ stalls
        add(1, LD, 0, 1, F_RDY, "ld_fetch");
        add(1, LD, 0, 1, DEC,   "ld_decode");
        add(1, LD, 0, 1, MADR,  "ld_adr");
        add(1, LD, 0, 0, MRD,   "ld_wait1");
        add(1, LD, 0, 0, MRD,   "ld_wait2");
        add(1, LD, 0, 1, MRD,   "ld_rdy");
        add(1, LD, 0, 1, MWB,   "ld_wb");
        // beq taken then not taken
        add(1, BQ, 1, 1, F_RDY, "beq1_fetch");
        add(1, BQ, 1, 1, DEC,   "beq1_decode");
        add(1, BQ, 1, 1, BEQ_T, "beq_taken");
        add(1, BQ, 0, 1, F_RDY, "beq2_fetch");
        add(1, BQ, 0, 1, DEC,   "beq2_decode");
        add(1, BQ, 0, 1, BEQ_N, "beq_not_taken");
        // jal, jalr
        add(1, JL, 0, 1, F_RDY, "jal_fetch");
        add(1, JL, 0, 1, DEC,   "jal_decode");
        add(1, JL, 0, 0, JMP,   "jal_jump");
        add(1, JL, 0, 1, AWB,   "jal_wb");
        add(1, JR, 0, 1, F_RDY, "jalr_fetch");
        add(1, JR, 0, 1, DEC,   "jalr_decode");
        add(1, JR, 0, 1, JADR,  "jalr_adr");
        add(1, JR, 0, 1, JMP,   "jalr_jump");
        add(1, JR, 0, 1, AWB,   "jalr_wb");
        // I-type, lui, auipc with a fetch stall
        add(1, I,  0, 1, F_RDY, "i_fetch");
        add(1, I,  0, 1, DEC,   "i_decode");
        add(1, I,  0, 1, EXI,   "i_exec");
        add(1, I,  0, 1, AWB,   "i_wb");
        add(1, LU, 0, 1, F_RDY, "lui_fetch");
        add(1, LU, 0, 1, DEC,   "lui_decode");
        add(1, LU, 0, 1, LUI_O, "lui_exec");
        add(1, LU, 0, 1, AWB,   "lui_wb");
        add(1, AU, 0, 0, F_WAIT,"au_fwait");
        add(1, AU, 0, 1, F_RDY, "au_fetch");
        add(1, AU, 0, 1, DEC,   "au_decode");
        add(1, AU, 0, 1, AWB,   "au_wb");
        // Store with one stall
        add(1, ST, 0, 1, F_RDY, "st_fetch");
        add(1, ST, 0, 1, DEC,   "st_decode");
        add(1, ST, 0, 1, MADR,  "st_adr");
        add(1, ST, 0, 0, MWR_W, "st_wait");
        add(1, ST, 0, 1, MWR_R, "st_done");
        // Illegal opcode traps, sticky for 10+ cycles, cleared by reset
        add(1, BADOP, 0, 1, F_RDY, "ill_fetch");
        add(1, BADOP, 0, 1, DEC,   "ill_decode");
        for (int i = 0; i < 11; i++) add(1, BADOP, i[0], i[1], ILL, "ill_hold");
        add(0, BADOP, 0, 1, Z,      "ill_reset");
        add(1, R,     0, 0, F_WAIT, "ill_after");
        // Reset while MEM_WRITE waits on mem_ready
        add(1, ST, 0, 1, F_RDY, "rs_fetch");
        add(1, ST, 0, 1, DEC,   "rs_decode");
        add(1, ST, 0, 1, MADR,  "rs_adr");
        add(1, ST, 0, 0, MWR_W, "rs_wait");
        add(0, ST, 0, 0, Z,     "rs_reset");
        add(1, ST, 0, 1, F_RDY, "rs_refetch");
        add(1, ST, 0, 1, DEC,   "rs_redecode");

        foreach (vecs[k]) begin
            @(negedge clk);
            reset_n   = vecs[k].rst_n;
            opcode    = vecs[k].op;
            zero      = vecs[k].z;
            mem_ready = vecs[k].rdy;
            #1;
            total++;
            if (actual() !== vecs[k].exp) begin
                bad++;
                $display("FAIL vec[%0d] %s: got %05h want %05h",
                         k, vecs[k].tag, actual(), vecs[k].exp);
            end
        end

        // Return to FETCH before the latency sequences
        @(negedge clk); reset_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        #1;
        total++;
        if (actual() !== F_RDY) begin
            bad++;
            $display("FAIL lat_start: got %05h want %05h", actual(), F_RDY);
        end
        // First cycle above is this instruction's FETCH; finish that R-type
        latency(R, 0, 0, 3, "r_tail");
        latency(AU, 0, 0, 3, "auipc");
        latency(BQ, 1, 0, 3, "beq");
        latency(R,  0, 0, 4, "rtype");
        latency(I,  0, 0, 4, "itype");
        latency(LU, 0, 0, 4, "lui");
        latency(ST, 0, 0, 4, "store");
        latency(JL, 0, 0, 4, "jal");
        latency(LD, 0, 0, 5, "load");
        latency(JR, 0, 0, 5, "jalr");
        latency(LD, 0, 2, 7, "load_fstall2");
        latency(R,  0, 3, 7, "rtype_fstall3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
